enum_alu_seq: RTL and testbench

//  Parametrised sequential ALU driven by operation_pkg::operation_t opcodes. Accepts one

---
 rtl/enum_alu_seq.sv | 239 +++++++++++++++++++++++
 tb/tb_enum_alu_seq.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enum_alu_seq.sv
// enum_alu_seq: sequential ALU on operation_pkg::operation_t opcodes.
// Single-cycle ops plus an iterative restoring divider.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   in_valid/in_ready   request handshake (in_ready has a comb path
//                       from out_ready)
//   in_op/in_a/in_b     raw 3-bit opcode and unsigned operands
//   out_valid/out_ready result handshake
//   out_result/out_op   result and opcode of the completed op
//   out_err             INVALID opcode or divide by zero
//
// Build option: define ENUM_ALU_SAT_EN to make ADD/MUL saturate
// to all ones and SUB clamp to zero instead of wrapping.

package operation_pkg;
    typedef enum logic [2:0] {
        OP_ADD     = 3'd0,
        OP_SUB     = 3'd1,
        OP_MUL     = 3'd2,
        OP_DIV     = 3'd3,
        OP_AND     = 3'd4,
        OP_OR      = 3'd5,
        OP_XOR     = 3'd6,
        OP_INVALID = 3'd7
    } operation_t;
endpackage

module enum_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [2:0]       out_op,
    output logic             out_err
);
    import operation_pkg::*;

    localparam int CW = $clog2(WIDTH + 1);

`ifdef ENUM_ALU_SAT_EN
    localparam bit LP_SAT = 1'b1;
`else
    localparam bit LP_SAT = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_result;
    operation_t       r_op;
    logic             r_err;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_cnt;

    operation_t       w_op;
    logic             w_accept;
    logic             w_div_start;
    logic             w_div_last;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_err;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    // ---------------- request decode ----------------
    assign w_op        = operation_t'(in_op);
    assign w_accept    = in_valid && in_ready;
    assign w_div_start = (w_op == OP_DIV) && (in_b != '0);
    assign w_div_last  = (r_cnt == CW'(WIDTH - 1));

    // ---------------- single-cycle ALU ----------------
    // Extra carry/borrow/high-product bits feed the saturation
    // option; with it disabled they are simply ignored.
    assign w_sum  = {1'b0, in_a} + {1'b0, in_b};
    assign w_diff = {1'b0, in_a} - {1'b0, in_b};
    assign w_prod = {{WIDTH{1'b0}}, in_a} * {{WIDTH{1'b0}}, in_b};

    always_comb begin
        w_alu_res = '0;
        w_alu_err = 1'b0;
        unique case (w_op)
            OP_ADD: begin
                w_alu_res = (LP_SAT && w_sum[WIDTH]) ?
                            '1 : w_sum[WIDTH-1:0];
            end
            OP_SUB: begin
                w_alu_res = (LP_SAT && w_diff[WIDTH]) ?
                            '0 : w_diff[WIDTH-1:0];
            end
            OP_MUL: begin
                w_alu_res = (LP_SAT && (|w_prod[2*WIDTH-1:WIDTH])) ?
                            '1 : w_prod[WIDTH-1:0];
            end
            // Only reached with b==0; b!=0 goes to the divider.
            OP_DIV: begin
                w_alu_res = '1;
                w_alu_err = 1'b1;
            end
            OP_AND: w_alu_res = in_a & in_b;
            OP_OR:  w_alu_res = in_a | in_b;
            OP_XOR: w_alu_res = in_a ^ in_b;
            OP_INVALID: begin
                w_alu_res = '0;
                w_alu_err = 1'b1;
            end
        endcase
    end

    // ---------------- restoring divider step ----------------
    // r_quo starts as the dividend and shifts left one bit per
    // cycle; quotient bits enter at the LSB, so after WIDTH steps
    // it holds the quotient. Since r_rem < divisor, the trial
    // subtraction's top bit is a clean borrow flag.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_trial   = w_shift - {1'b0, r_div};
    assign w_qbit    = ~w_trial[WIDTH];
    assign w_rem_nxt = w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_qbit};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_div_start ? S_DIV : S_OUT;
                end
            end
            S_DIV: begin
                if (w_div_last) begin
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (w_accept) begin
                    w_state_nxt = w_div_start ? S_DIV : S_OUT;
                end else if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // in_ready looks through to out_ready so a draining result
    // and a new request can share the same edge.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            S_IDLE: in_ready = 1'b1;
            S_DIV:  in_ready = 1'b0;
            S_OUT: begin
                in_ready  = out_ready;
                out_valid = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // ---------------- datapath ----------------
    // Result/op/err only change when a result is produced, so they
    // keep their last value after out_valid drops and during DIV.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_op     <= OP_ADD;
            r_err    <= 1'b0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
        end else if (r_state == S_DIV) begin
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            if (w_div_last) begin
                r_cnt    <= '0;
                r_result <= w_quo_nxt;
                r_op     <= OP_DIV;
                r_err    <= 1'b0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end else if (w_accept) begin
            if (w_div_start) begin
                r_rem <= '0;
                r_quo <= in_a;
                r_div <= in_b;
                r_cnt <= '0;
            end else begin
                r_result <= w_alu_res;
                r_op     <= w_op;
                r_err    <= w_alu_err;
            end
        end
    end

    assign out_result = r_result;
    assign out_op     = r_op;
    assign out_err    = r_err;

endmodule

// File: tb/tb_enum_alu_seq.sv
// Testbench for enum_alu_seq: directed scenarios plus random ops,
// checked by a scoreboard fed from an arithmetic reference model.
module tb_enum_alu_seq;
    localparam int W = 8;

`ifdef ENUM_ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic [2:0]   out_op;
    logic         out_err;

    enum_alu_seq #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_op(in_op),
        .in_a(in_a),
        .in_b(in_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_result(out_result),
        .out_op(out_op),
        .out_err(out_err)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    int     nout   = 0;
    longint cyc    = 0;
    bit     rnd_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        logic [2:0]   op;
        logic         err;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the op's definition.
    function automatic exp_t model(input int op, input int a,
                                   input int b);
        exp_t e;
        int   m;
        int   r;
        m     = 1 << W;
        r     = 0;
        e.op  = 3'(op);
        e.err = 1'b0;
        case (op)
            0: begin r = a + b; if (SAT && r >= m) r = m - 1; end
            1: begin r = a - b; if (SAT && r < 0) r = 0; end
            2: begin r = a * b; if (SAT && r >= m) r = m - 1; end
            3: begin
                if (b == 0) begin r = m - 1; e.err = 1'b1; end
                else r = a / b;
            end
            4: r = a & b;
            5: r = a | b;
            6: r = a ^ b;
            default: begin r = 0; e.err = 1'b1; end
        endcase
        e.res = r[W-1:0];
        return e;
    endfunction

    // Monitor: a transfer happens at the next rising edge whenever
    // out_valid && out_ready is seen at the falling edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got res=%0h op=%0d expected none",
                         out_result, out_op);
            end else begin
                exp_t e;
                e = q.pop_front();
                nout++;
                chk("result", 32'(out_result), 32'(e.res));
                chk("op", 32'(out_op), 32'(e.op));
                chk("err", 32'(out_err), 32'(e.err));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int op, input int a, input int b,
                        input bit push, output longint acc);
        int n;
        in_valid = 1'b1;
        in_op    = 3'(op);
        in_a     = W'(a);
        in_b     = W'(b);
        n        = 0;
        acc      = -1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 300) break;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        acc = cyc;
        if (push) q.push_back(model(op, a, b));
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat, output int nbusy);
        lat   = 1;
        nbusy = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) nbusy++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        longint acc;
        longint accs[4];
        int     lat;
        int     nbusy;
        int     base;
        bit     seen;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = '0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(1);

        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_result", 32'(out_result), 0);
        chk("rst_op", 32'(out_op), 0);
        chk("rst_err", 32'(out_err), 0);

        // 1: ADD latency 1
        send(0, 10, 5, 1'b1, acc);
        wait_valid(lat, nbusy);
        chk("add_latency", 32'(lat), 1);
        chk("add_result", 32'(out_result), 15);

        // 2: DIV 200/7
        idle(2);
        send(3, 200, 7, 1'b1, acc);
        wait_valid(lat, nbusy);
        chk("div_latency", 32'(lat), W + 1);
        chk("div_busy_cycles", 32'(nbusy), W);
        chk("div_result", 32'(out_result), 28);

        // 3: DIV by zero, INVALID
        idle(2);
        send(3, 9, 0, 1'b1, acc);
        wait_valid(lat, nbusy);
        chk("div0_latency", 32'(lat), 1);
        chk("div0_result", 32'(out_result), 32'hFF);
        chk("div0_err", 32'(out_err), 1);
        idle(2);
        send(7, 33, 44, 1'b1, acc);
        wait_valid(lat, nbusy);
        chk("inv_latency", 32'(lat), 1);
        chk("inv_err", 32'(out_err), 1);

        // 4: SUB/MUL wrap or saturate
        idle(2);
        send(1, 5, 10, 1'b1, acc);
        chk("sub_result", 32'(out_result), SAT ? 32'h00 : 32'hFB);
        idle(1);
        send(2, 20, 20, 1'b1, acc);
        chk("mul_result", 32'(out_result), SAT ? 32'hFF : 32'h90);

        // 5: backpressure then back-to-back stream
        idle(2);
        out_ready = 1'b0;
        send(6, 8'hF0, 8'h3C, 1'b1, acc);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_result", 32'(out_result), 32'hCC);
            chk("hold_in_ready", 32'(in_ready), 0);
            idle(1);
        end
        base      = nout;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(4, $urandom_range(0, 255), $urandom_range(0, 255),
                 1'b1, acc);
            accs[i] = acc;
        end
        for (int i = 1; i < 4; i++)
            chk("stream_gap", 32'(accs[i] - accs[i-1]), 1);
        idle(4);
        chk("stream_outputs", 32'(nout - base), 5);

        // 6: reset mid-DIV aborts the op
        idle(2);
        send(3, 200, 7, 1'b0, acc);
        idle(3);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 1);
        chk("abort_out_valid", 32'(out_valid), 0);
        chk("abort_result", 32'(out_result), 0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen = 1'b1;
            idle(1);
        end
        chk("abort_no_output", 32'(seen), 0);

        // Random traffic with random sink backpressure
        rnd_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int op;
            int a;
            int b;
            op = $urandom_range(0, 7);
            a  = $urandom_range(0, 255);
            b  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 255);
            send(op, a, b, 1'b1, acc);
            idle($urandom_range(0, 2));
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        idle(30);
        chk("queue_drained", 32'(q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
